// File: rtl/mano_seq_ctrl.sv
// Mano computer timing/sequence control: sequence counter, opcode/indirect decode latch,
// HALT/START run control and a sticky runaway-instruction flag.
module mano_seq_ctrl #(
    parameter int SC_W     = 3,
    parameter int T_DECODE = 2,
    parameter int T_LAST   = 7
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [15:0]     IN_IR,
    input  logic            SC_CLR,
    input  logic            HLT,
    input  logic            START,
    output logic [SC_W-1:0] t,
    output logic [7:0]      D,
    output logic            I,
    output logic            RUN,
    output logic            ERR
);

    typedef enum logic {
        HALTED  = 1'b0,
        RUNNING = 1'b1
    } state_e;

    localparam logic [SC_W-1:0] T_DEC_C  = SC_W'(T_DECODE);
    localparam logic [SC_W-1:0] T_LAST_C = SC_W'(T_LAST);

    state_e          state_q;
    logic [SC_W-1:0] t_q;
    logic [7:0]      d_q;
    logic            i_q;
    logic            err_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= HALTED;
            t_q     <= '0;
            d_q     <= 8'h00;
            i_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                // t is already 0 here, so the first running cycle is T0
                HALTED: begin
                    if (START) state_q <= RUNNING;
                end
                RUNNING: begin
                    // Decode latch is independent of SC_CLR in the same cycle
                    if (t_q == T_DEC_C) begin
                        d_q <= 8'h01 << IN_IR[14:12];
                        i_q <= IN_IR[15];
                    end
                    if (SC_CLR) begin
                        t_q <= '0;
                        if (HLT) state_q <= HALTED;
                    end else if (t_q == T_LAST_C) begin
                        t_q   <= '0;
                        err_q <= 1'b1;
                    end else begin
                        t_q <= t_q + SC_W'(1);
                    end
                end
                default: state_q <= HALTED;
            endcase
        end
    end

    assign t   = t_q;
    assign D   = d_q;
    assign I   = i_q;
    assign RUN = (state_q == RUNNING);
    assign ERR = err_q;

endmodule

// File: doc/mano_seq_ctrl.md
Name: mano_seq_ctrl

Overview:
- Timing/sequence control stage of the Mano computer; sits directly upstream of the address register.
- Owns the sequence counter that produces the 3-bit timing code t consumed by the AR, IR, PC and ALU registers.
- Latches the decoded opcode (D0..D7) and the indirect bit I from the instruction register at decode time.
- Handles instruction completion (SC clear), HALT/START run control and a sticky runaway-instruction flag.

Parameters:
- SC_W, 3, width of the sequence counter and of t.
- T_DECODE, 2, t value at which the opcode and I are latched from IN_IR.
- T_LAST, 7, highest legal t value; SC wraps after it.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- IN_IR  input  16  current instruction register contents; [15]=I, [14:12]=opcode, [11:0]=address.
- SC_CLR  input  1  end of instruction from execute logic; next t is 0.
- HLT  input  1  halt request, sampled only when SC_CLR is also high.
- START  input  1  leaves the halted state.
- t  output  SC_W  current timing state T0..T7, binary encoded.
- D  output  8  one-hot decoded opcode, D[n] = (opcode == n).
- I  output  1  latched indirect bit.
- RUN  output  1  1 while the processor is executing.
- ERR  output  1  sticky flag: SC wrapped past T_LAST without SC_CLR.

Behaviour:
- Reset (RST_N low, async): t=0, D=8'h00, I=0, RUN=0, ERR=0. Held while RST_N is low; release is synchronous to CLK.
- States:
  - HALTED: RUN=0, t held at 0, D and I held.
  - RUNNING: RUN=1, t advances.
- HALTED -> RUNNING: on a clock with START=1. t stays 0 on that edge, so T0 is the first cycle with RUN=1.
- RUNNING, each edge, in priority order:
  - SC_CLR=1 and HLT=1: t<=0, go to HALTED.
  - SC_CLR=1: t<=0.
  - t==T_LAST: t<=0, ERR<=1.
  - Otherwise: t<=t+1.
- START while RUNNING is ignored. HLT without SC_CLR is ignored.
- Decode latch: on an edge where RUNNING and t==T_DECODE:
  - D <= onehot(IN_IR[14:12]); I <= IN_IR[15].
  - D and I hold all other cycles, including across SC_CLR, until the next T_DECODE.
  - If SC_CLR is high in the same cycle, the latch still occurs (latch and clear are independent).
- Latency:
  - t changes one cycle after the qualifying edge.
  - D and I are valid from the cycle following T2 (i.e. during T3), which AR uses for its indirect load.
- ERR clears only on reset.
- Reset mid-instruction: all outputs return to reset values immediately, with no clock needed.
- Width rules: t is unsigned SC_W bits. Increment wraps naturally only via the T_LAST rule. SC_W must be >= clog2(T_LAST+1).

Test Plan:
- Reset then idle: RST_N=0 for 2 clocks, release, START=0 for 4 clocks -> t=0, RUN=0, D=8'h00, I=0, ERR=0 throughout.
- Start and count: pulse START=1 one clock -> RUN=1; t sequence 0,1,2,3,4 on successive edges; no ERR.
- Decode: IN_IR=16'h5123, run to T2 -> from T3 on, D=8'b0010_0000 and I=0. Next instruction IN_IR=16'hD123 -> D=8'b0010_0000 and I=1 after that instruction's T2.
- Instruction completion: assert SC_CLR at t=4 -> next t=0, then 1,2,…; D holds 8'b0010_0000 until the next T2.
- Halt: HLT=1 with SC_CLR=1 at t=5 -> t=0, RUN=0. HLT=1 alone at t=3 -> ignored, t=4. START after halt -> resumes at T0.
- Runaway and async reset: never assert SC_CLR -> after t=7, t=0 and ERR=1, staying 1 through later instructions. Drop RST_N mid-cycle at t=3 -> t, D, I, RUN, ERR go to 0 before the next CLK edge.
